// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, derived sync windows and text-cell helpers.
// Shared by the sync generator, display and text-render blocks.
package vga_timing_pkg;

    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SW  = 96;
    localparam int H_BP  = 48;
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;

    localparam int V_VIS = 480;
    localparam int V_FP  = 10;
    localparam int V_SW  = 2;
    localparam int V_BP  = 33;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 12;

    localparam logic [CNT_W-1:0] H_VIS_C      = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C      = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VIS + H_FP + H_SW - 1);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VIS + V_FP + V_SW - 1);

    typedef struct packed {
        logic              hs;
        logic              vs;
        logic              video_on;
        logic [CNT_W-1:0]  x;
        logic [CNT_W-1:0]  y;
        logic [ADDR_W-1:0] char_addr;
        logic              frame_start;
    } vga_out_t;

    localparam vga_out_t OUT_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

    // row*80 as row*64 + row*16 keeps the cell address multiplier-free
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v
    );
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = {6'd0, v[9:4]};
        col = {5'd0, h[9:3]};
        return (row << 6) + (row << 4) + col;
    endfunction

endpackage

// File: rtl/vga_sync_mod_counter.sv
// Modulo-N counter with enable; wrap is high on the enabled cycle
// where the count rolls over from MOD-1 to 0.
module mod_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel-enabled h/v counters plus a registered
// decode stage for syncs, visible window, coordinates and text cell.
module vga_sync
    import vga_timing_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk25,
    output logic              hs,
    output logic              vs,
    output logic              video_on,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic [ADDR_W-1:0] char_addr,
    output logic              frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap_q;
    logic             vis;
    vga_out_t         nxt;
    vga_out_t         out_q;

    mod_counter #(.MOD(H_TOT), .W(CNT_W)) u_h (
        .clk  (clk),
        .rst  (rst),
        .en   (clk25),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    mod_counter #(.MOD(V_TOT), .W(CNT_W)) u_v (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    // Counters reached (0,0) by wrapping on the previous edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_wrap_q <= 1'b0;
        end else begin
            frame_wrap_q <= v_wrap;
        end
    end

    assign vis = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);

    always_comb begin
        nxt             = OUT_RST;
        nxt.hs          = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
        nxt.vs          = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));
        nxt.video_on    = vis;
        nxt.x           = h_cnt;
        nxt.y           = v_cnt;
        nxt.char_addr   = vis ? cell_addr(h_cnt, v_cnt) : '0;
        nxt.frame_start = frame_wrap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= nxt;
        end
    end

    assign hs          = out_q.hs;
    assign vs          = out_q.vs;
    assign video_on    = out_q.video_on;
    assign x           = out_q.x;
    assign y           = out_q.y;
    assign char_addr   = out_q.char_addr;
    assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: directed scenarios plus random pixel-enable traffic
// checked against an arithmetic frame-position model.
module tb_vga_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk25;
    logic        hs;
    logic        vs;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] char_addr;
    logic        frame_start;

    logic [9:0]  fh;
    logic [9:0]  fv;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    int mh;
    int mv;
    bit pend;
    int cyc;

    vga_sync dut (
        .clk         (clk),
        .rst         (rst),
        .clk25       (clk25),
        .hs          (hs),
        .vs          (vs),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .char_addr   (char_addr),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_pos(input int h, input int v, input bit fs);
        bit vis;
        vis = (h < 640) && (v < 480);
        chk("x", 32'(x), h);
        chk("y", 32'(y), v);
        chk("hs", 32'(hs), (h >= 656 && h <= 751) ? 0 : 1);
        chk("vs", 32'(vs), (v >= 490 && v <= 491) ? 0 : 1);
        chk("video_on", 32'(video_on), vis ? 1 : 0);
        chk("char_addr", 32'(char_addr), vis ? (v / 16) * 80 + h / 8 : 0);
        chk("frame_start", 32'(frame_start), fs ? 1 : 0);
    endtask

    task automatic expect_reset();
        chk("rst_hs", 32'(hs), 1);
        chk("rst_vs", 32'(vs), 1);
        chk("rst_video_on", 32'(video_on), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_char_addr", 32'(char_addr), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
    endtask

    task automatic model_reset();
        mh   = 0;
        mv   = 0;
        pend = 1'b0;
    endtask

    // One clk edge; outputs show the position held before the edge
    task automatic tick(input bit en);
        int  eh;
        int  ev;
        bit  efs;
        clk25 = en;
        @(posedge clk);
        cyc++;
        eh   = mh;
        ev   = mv;
        efs  = pend;
        pend = 1'b0;
        if (en) begin
            mh++;
            if (mh == 800) begin
                mh = 0;
                mv++;
                if (mv == 525) begin
                    mv   = 0;
                    pend = 1'b1;
                end
            end
        end
        #1;
        expect_pos(eh, ev, efs);
    endtask

    task automatic set_pos(input int h, input int v);
        bit efs;
        clk25 = 1'b0;
        fh = 10'(h);
        fv = 10'(v);
        force dut.u_h.cnt = fh;
        force dut.u_v.cnt = fv;
        @(posedge clk);
        cyc++;
        #1;
        release dut.u_h.cnt;
        release dut.u_v.cnt;
        efs  = pend;
        pend = 1'b0;
        mh   = h;
        mv   = v;
        expect_pos(h, v, efs);
    endtask

    initial begin
        int low_cnt;
        int first_low;
        int fall1;
        int fall2;
        int fs_cnt;
        int fs_at_origin;
        bit prev;

        cyc   = 0;
        rst   = 1'b1;
        clk25 = 1'b0;
        fh    = '0;
        fv    = '0;
        model_reset();
        #3;
        expect_reset();
        @(negedge clk);
        rst = 1'b0;

        // Enable low: counters hold at the origin
        for (int i = 0; i < 4; i++) tick(1'b0);

        // Continuous enable across one full line
        low_cnt   = 0;
        first_low = -1;
        for (int i = 1; i <= 801; i++) begin
            tick(1'b1);
            if (hs === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (i == 800) chk("y_before_801", 32'(y), 0);
        end
        chk("hs_low_len", low_cnt, 96);
        chk("hs_first_low_edge", first_low, 657);
        chk("y_at_801", 32'(y), 1);

        // Nominal 1-in-4 enable: hsync period
        model_reset();
        rst = 1'b1;
        #1;
        expect_reset();
        @(negedge clk);
        rst   = 1'b0;
        fall1 = -1;
        fall2 = -1;
        prev  = hs;
        for (int i = 0; i < 6400; i++) begin
            tick(i % 4 == 0);
            if (prev === 1'b1 && hs === 1'b0) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            prev = hs;
        end
        chk("hs_period", fall2 - fall1, 3200);

        // Nominal enable through the vsync window
        set_pos(0, 489);
        low_cnt = 0;
        for (int i = 0; i < 10400; i++) begin
            tick(i % 4 == 0);
            if (vs === 1'b0) low_cnt++;
        end
        chk("vs_low_len", low_cnt, 6400);

        // Text-cell address corners
        set_pos(15, 31);
        tick(1'b1);
        set_pos(639, 479);
        tick(1'b1);
        chk("char_addr_max", 32'(char_addr), 2399);
        set_pos(640, 0);
        tick(1'b1);
        chk("char_addr_blank", 32'(char_addr), 0);
        chk("video_on_blank", 32'(video_on), 0);

        // Frame wrap with continuous enable
        set_pos(790, 524);
        fs_cnt       = 0;
        fs_at_origin = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1'b1);
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (x === 10'd0 && y === 10'd0) fs_at_origin++;
            end
        end
        chk("frame_start_count", fs_cnt, 1);
        chk("frame_start_origin", fs_at_origin, 1);

        // Random positions and random enable patterns
        for (int r = 0; r < 6; r++) begin
            set_pos($urandom_range(0, 799), $urandom_range(0, 524));
            for (int i = 0; i < 400; i++) tick(1'($urandom_range(0, 1)));
        end
        set_pos(798, 524);
        for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 2) != 0));

        // Mid-frame reset between edges
        set_pos(400, 200);
        for (int i = 0; i < 3; i++) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        expect_reset();
        model_reset();
        @(negedge clk);
        expect_reset();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick(1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
